// File: rtl/fx2_pin_monitor.sv
// fx2_pin_monitor: synchronise, edge-count and display FX2 header pins on the board LEDs.
// Define FX2_GLITCH_FILTER_EN to build a FILT_LEN-cycle stability filter per pin.
module fx2_pin_monitor #(
    parameter int NUM_PINS    = 22,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SCAN_DIV    = 50_000_000,
    parameter int IDX_W       = 6,
    parameter int FILT_LEN    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pins,
    input  logic                clear_counts,
    input  logic                scan_mode,
    input  logic [IDX_W-1:0]    sel_idx,
    output logic [7:0]          led,
    output logic [IDX_W-1:0]    cur_idx,
    output logic [CNT_W-1:0]    cur_count,
    output logic [NUM_PINS-1:0] activity
);
    localparam int NI    = 2**IDX_W;
    localparam int DIV_W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic {MANUAL, SCAN} state_t;
    state_t state, state_n;
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] lvl, lvl_d, edges;
    logic [CNT_W-1:0]    cnt [NUM_PINS];
    logic [CNT_W-1:0]    cnt_pad [NI];
    logic [NI-1:0]       lvl_pad, act_pad;
    logic [DIV_W-1:0]    div, div_n;
    logic [IDX_W-1:0]    idx_n;
    logic                div_end;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
`ifdef FX2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] fcnt [NUM_PINS];
    // lvl follows the synchroniser only once it has disagreed for FILT_LEN straight cycles
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PINS; i++) begin
            if (rst || sync_q[SYNC_STAGES-1][i] == lvl[i]) begin
                fcnt[i] <= '0;
                if (rst) lvl[i] <= 1'b0;
            end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                fcnt[i] <= '0;
                lvl[i]  <= sync_q[SYNC_STAGES-1][i];
            end else begin
                fcnt[i] <= fcnt[i] + 1'b1;
            end
        end
    end
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif
    assign edges = lvl ^ lvl_d;
    always_ff @(posedge clk) begin
        if (rst || clear_counts) begin
            lvl_d    <= rst ? '0 : lvl;
            activity <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
        end else begin
            lvl_d    <= lvl;
            activity <= activity | edges;
            for (int i = 0; i < NUM_PINS; i++)
                if (edges[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end
    end
    always_ff @(posedge clk) state <= rst ? MANUAL : state_n;
    always_comb state_n = scan_mode ? SCAN : MANUAL;
    always_comb begin
        div_end = div == DIV_W'(SCAN_DIV - 1);
        idx_n   = !scan_mode ? sel_idx :
                  state == MANUAL ? '0 :
                  !div_end ? cur_idx :
                  cur_idx == IDX_W'(NUM_PINS - 1) ? '0 : cur_idx + 1'b1;
        div_n   = (!scan_mode || state == MANUAL || div_end) ? '0 : div + 1'b1;
    end
    // Pad per-pin state to the full index space so out-of-range selects read as zero
    always_comb begin
        lvl_pad = NI'(lvl);
        act_pad = NI'(activity);
        for (int i = 0; i < NI; i++) cnt_pad[i] = '0;
        for (int i = 0; i < NUM_PINS; i++) cnt_pad[i] = cnt[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx   <= '0;
            div       <= '0;
            led       <= '0;
            cur_count <= '0;
        end else begin
            cur_idx   <= idx_n;
            div       <= div_n;
            led       <= {6'(cur_idx), act_pad[cur_idx], lvl_pad[cur_idx]};
            cur_count <= cnt_pad[cur_idx];
        end
    end
endmodule

// File: tb/tb_fx2_pin_monitor.sv
// tb_fx2_pin_monitor: directed checks of sync latency, counting, clear, scan and selection.
module tb_fx2_pin_monitor;
`ifdef FX2_GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif
    logic        clk = 0, rst = 1, clear_counts = 0, scan_mode = 0;
    logic [21:0] pins = '0;
    logic [5:0]  sel_idx = '0;
    logic [7:0]  led;
    logic [5:0]  cur_idx;
    logic [3:0]  cur_count;
    logic [21:0] activity;
    int checks = 0, errors = 0;

    fx2_pin_monitor #(.NUM_PINS(22), .CNT_W(4), .SYNC_STAGES(2), .SCAN_DIV(4),
                      .IDX_W(6), .FILT_LEN(4)) dut (
        .clk(clk), .rst(rst), .pins(pins), .clear_counts(clear_counts),
        .scan_mode(scan_mode), .sel_idx(sel_idx), .led(led), .cur_idx(cur_idx),
        .cur_count(cur_count), .activity(activity)
    );

    always #5 clk = ~clk;

    typedef struct {logic [5:0] sel; logic [3:0] cnt; logic [7:0] led;} vec_t;
    vec_t tbl[7];

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic toggle(int p, int hold);
        pins[p] = ~pins[p];
        tick(hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // sel, expected count, expected led {idx, activity, level}
        tbl[0] = '{6'd0,  4'd1, 8'h02};
        tbl[1] = '{6'd5,  4'd0, 8'h15};
        tbl[2] = '{6'd7,  4'd0, 8'h1C};
        tbl[3] = '{6'd30, 4'd0, 8'h78};
        tbl[4] = '{6'd32, 4'd0, 8'h80};
        tbl[5] = '{6'd37, 4'd0, 8'h94};
        tbl[6] = '{6'd21, 4'd0, 8'h54};

        tick(3);
        chk("reset_led", led, 0);
        chk("reset_count", cur_count, 0);
        chk("reset_activity", activity, 0);
        chk("reset_idx", cur_idx, 0);
        rst = 0;

        sel_idx = 5;
        tick(3);
        chk("manual_idx", cur_idx, 5);
        pins[5] = 1;
        tick(3 + FL);
        chk("latency_before", cur_count, 0);
        tick(1);
        chk("latency_first", cur_count, 1);
        tick(6);
        toggle(5, 10);
        toggle(5, 10);
        chk("manual_count", cur_count, 3);
        chk("manual_activity", activity, 22'h20);
        chk("manual_led", led, 8'h17);

        sel_idx = 0;
        for (int i = 0; i < 20; i++) toggle(0, 6 + FL);
        tick(2);
        chk("saturate", cur_count, 15);
        chk("sat_activity", activity, 22'h21);

        pins[0] = 1;
        tick(2 + FL);
        clear_counts = 1;
        tick(1);
        clear_counts = 0;
        chk("clear_activity", activity, 0);
        tick(3);
        chk("clear_count", cur_count, 0);
        pins[0] = 0;
        tick(6 + FL);
        chk("after_clear_count", cur_count, 1);

        foreach (tbl[i]) begin
            sel_idx = tbl[i].sel;
            tick(2);
            chk($sformatf("tbl%0d_idx", i), cur_idx, tbl[i].sel);
            chk($sformatf("tbl%0d_count", i), cur_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_led", i), led, tbl[i].led);
        end

        scan_mode = 1;
        tick(1);
        chk("scan_entry", cur_idx, 0);
        for (int k = 1; k <= 22; k++) begin
            tick(3);
            chk($sformatf("scan_hold%0d", k), cur_idx, k - 1);
            tick(1);
            chk($sformatf("scan_step%0d", k), cur_idx, k % 22);
        end
        tick(4 * 9);
        chk("scan_at9", cur_idx, 9);
        rst = 1;
        tick(1);
        chk("scan_reset_idx", cur_idx, 0);
        chk("scan_reset_activity", activity, 0);
        rst = 0;
        tick(1);
        chk("scan_restart", cur_idx, 0);
        tick(4);
        chk("scan_restart_step", cur_idx, 1);

        scan_mode = 0;
        sel_idx = 3;
        tick(10);
        clear_counts = 1;
        tick(1);
        clear_counts = 0;
        pins[3] = 1;
        tick(2);
        pins[3] = 0;
        tick(12);
        chk("glitch_short", cur_count, FL != 0 ? 0 : 2);
        pins[3] = 1;
        tick(6);
        pins[3] = 0;
        tick(12);
        chk("glitch_long", cur_count, FL != 0 ? 2 : 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
